// File: rtl/cmd_cntrl.sv
// Command/destination controller ahead of motion_cntrl: accepts UART commands and
// barcode station IDs, drives the go enable, and sounds the obstacle buzzer.
module cmd_cntrl #(
    parameter int BUZZ_DIV = 12500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd,
    input  logic       cmd_rdy,
    output logic       clr_cmd_rdy,
    input  logic [7:0] ID,
    input  logic       ID_vld,
    output logic       clr_ID_vld,
    input  logic       OK2Move,
    output logic       go,
    output logic       in_transit,
    output logic       buzz,
    output logic       buzz_n
);

    localparam int CNT_W = $clog2(BUZZ_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUZZ_DIV - 1);
    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_GO   = 2'b01;

    typedef enum logic {
        IDLE   = 1'b0,
        MOVING = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       dest_id_q, dest_id_d;
    logic [CNT_W-1:0] buzz_cnt_q, buzz_cnt_d;
    logic             buzz_q, buzz_d;
    logic             buzz_en;
    logic             id_match;

    // An ID only counts as an arrival when its upper bits are clear.
    assign id_match = (ID[7:6] == 2'b00) && (ID[5:0] == dest_id_q);

    always_comb begin
        state_d     = state_q;
        dest_id_d   = dest_id_q;
        clr_cmd_rdy = 1'b0;
        clr_ID_vld  = 1'b0;
        if (!rst) begin
            if (cmd_rdy) begin
                // Commands take priority; a pending ID waits for a cmd-free cycle.
                clr_cmd_rdy = 1'b1;
                if (cmd[7:6] == OP_GO) begin
                    dest_id_d = cmd[5:0];
                    state_d   = MOVING;
                end else if ((cmd[7:6] == OP_STOP) && (state_q == MOVING)) begin
                    state_d = IDLE;
                end
            end else if (ID_vld) begin
                clr_ID_vld = 1'b1;
                if ((state_q == MOVING) && id_match) begin
                    state_d = IDLE;
                end
            end
        end
    end

    assign in_transit = (state_q == MOVING);
    assign go         = in_transit & OK2Move;
    assign buzz_en    = in_transit & ~OK2Move;

    always_comb begin
        buzz_cnt_d = '0;
        buzz_d     = 1'b0;
        if (buzz_en) begin
            if (buzz_cnt_q == CNT_LAST) begin
                buzz_cnt_d = '0;
                buzz_d     = ~buzz_q;
            end else begin
                buzz_cnt_d = buzz_cnt_q + 1'b1;
                buzz_d     = buzz_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dest_id_q  <= 6'h00;
            buzz_cnt_q <= '0;
            buzz_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dest_id_q  <= dest_id_d;
            buzz_cnt_q <= buzz_cnt_d;
            buzz_q     <= buzz_d;
        end
    end

    assign buzz   = buzz_q;
    assign buzz_n = ~buzz_q;

endmodule

// File: tb/tb_cmd_cntrl.sv
// Directed bench for cmd_cntrl: each cycle pushes hand-derived expected outputs
// {clr_cmd_rdy, clr_ID_vld, go, in_transit, buzz, buzz_n} and compares them.
module tb_cmd_cntrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] cmd = 8'h00;
    logic       cmd_rdy = 1'b0;
    logic       clr_cmd_rdy;
    logic [7:0] ID = 8'h00;
    logic       ID_vld = 1'b0;
    logic       clr_ID_vld;
    logic       OK2Move = 1'b1;
    logic       go;
    logic       in_transit;
    logic       buzz;
    logic       buzz_n;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string      tag;
        logic [5:0] exp;
    } exp_t;

    exp_t sb[$];

    cmd_cntrl #(.BUZZ_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .ID         (ID),
        .ID_vld     (ID_vld),
        .clr_ID_vld (clr_ID_vld),
        .OK2Move    (OK2Move),
        .go         (go),
        .in_transit (in_transit),
        .buzz       (buzz),
        .buzz_n     (buzz_n)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, record the expected outputs,
    // then compare shortly after while inputs are stable.
    task automatic cyc(input string tag, input logic r, input logic [7:0] c, input logic cr,
                       input logic [7:0] id, input logic iv, input logic ok,
                       input logic [5:0] exp);
        exp_t e;
        logic [5:0] obs;
        @(negedge clk);
        rst     = r;
        cmd     = c;
        cmd_rdy = cr;
        ID      = id;
        ID_vld  = iv;
        OK2Move = ok;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
        #1;
        obs = {clr_cmd_rdy, clr_ID_vld, go, in_transit, buzz, buzz_n};
        e = sb.pop_front();
        n_checks++;
        assert (obs === e.exp) n_pass++;
        else $error("FAIL %s: observed=%b expected=%b", e.tag, obs, e.exp);
    endtask

    initial begin
        logic [5:0] ex;
        logic       b;
        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            cyc("reset", 1'b1, 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
                1'($urandom), 6'b000001);
        end
        // Idle behaviour
        cyc("idle_nop",     1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 6'b000001);
        cyc("idle_id_drop", 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 1'b1, 6'b010001);
        cyc("idle_stop",    1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 6'b100001);
        cyc("idle_ignored", 1'b0, 8'hC5, 1'b1, 8'h00, 1'b0, 1'b1, 6'b100001);
        cyc("idle_still",   1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 6'b000001);
        // Start and arrival
        cyc("start_ack",    1'b0, 8'h45, 1'b1, 8'h00, 1'b0, 1'b1, 6'b100001);
        cyc("moving",       1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 6'b001101);
        cyc("id03",         1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 1'b1, 6'b011101);
        cyc("id45",         1'b0, 8'h00, 1'b0, 8'h45, 1'b1, 1'b1, 6'b011101);
        cyc("id05",         1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 1'b1, 6'b011101);
        cyc("arrived",      1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 6'b000001);
        // Retarget with simultaneous ID: cmd wins, ID serviced next against new dest
        cyc("rt_start",     1'b0, 8'h45, 1'b1, 8'h00, 1'b0, 1'b1, 6'b100001);
        cyc("rt_both",      1'b0, 8'h47, 1'b1, 8'h07, 1'b1, 1'b1, 6'b101101);
        cyc("rt_id07",      1'b0, 8'h00, 1'b0, 8'h07, 1'b1, 1'b1, 6'b011101);
        cyc("rt_arrived",   1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 6'b000001);
        // STOP while moving
        cyc("st_start",     1'b0, 8'h45, 1'b1, 8'h00, 1'b0, 1'b1, 6'b100001);
        cyc("st_stop",      1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 6'b101101);
        cyc("st_idle",      1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 6'b000001);
        // Ignored opcode while moving
        cyc("ig_start",     1'b0, 8'h45, 1'b1, 8'h00, 1'b0, 1'b1, 6'b100001);
        cyc("ig_c5",        1'b0, 8'hC5, 1'b1, 8'h00, 1'b0, 1'b1, 6'b101101);
        cyc("ig_moving",    1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 6'b001101);
        // Obstacle: buzz toggles every 4 clocks while blocked
        for (int i = 0; i < 20; i++) begin
            b  = 1'((i / 4) % 2);
            ex = {4'b0001, b, ~b};
            cyc("obstacle", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, ex);
        end
        cyc("ob_clear",     1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 6'b001110);
        cyc("ob_quiet",     1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 6'b001101);
        cyc("ob_arrive",    1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 1'b1, 6'b011101);
        for (int i = 0; i < 6; i++) begin
            cyc("idle_blocked", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 6'b000001);
        end
        // Re-activation starts from counter 0
        cyc("ra_start",     1'b0, 8'h45, 1'b1, 8'h00, 1'b0, 1'b1, 6'b100001);
        cyc("ra_move",      1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 6'b001101);
        for (int i = 0; i < 6; i++) begin
            b  = 1'((i / 4) % 2);
            ex = {4'b0001, b, ~b};
            cyc("ra_obstacle", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, ex);
        end
        // Reset mid-transit with buzzer active (6 blocked edges -> buzz=1)
        cyc("mid_rst",      1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 6'b000110);
        cyc("post_rst_id",  1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 1'b1, 6'b010001);
        cyc("post_rst",     1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 6'b000001);
        cyc("post_rst_blk", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 6'b000001);

        n_checks++;
        assert (sb.size() == 0) n_pass++;
        else $error("FAIL scoreboard_empty: observed=%0d expected=0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
